// File: rtl/alu_share_arbiter_if.sv
// Requester, response and ALU-side signals of the shared-ALU arbiter.
// slave = arbiter side; master = requesters plus the ALU.
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [2:0]        req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              rsp0_valid;
  logic              rsp0_ready;

  logic              req1_valid;
  logic              req1_ready;
  logic [2:0]        req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              rsp1_valid;
  logic              rsp1_ready;

  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;

  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    input  alu_result, alu_zero,
    output req0_ready, rsp0_valid, req1_ready, rsp1_valid,
    output rsp_result, rsp_zero, alu_op, alu_a, alu_b
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    output alu_result, alu_zero,
    input  req0_ready, rsp0_valid, req1_ready, rsp1_valid,
    input  rsp_result, rsp_zero, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters; round-robin, or port 0 fixed priority with ARB_FIXED_PRIO_EN.
// Latency: accept at edge T, result captured and response valid from edge T+EXEC_CYCLES.
// Backpressure: one op in flight; new requests stall until the response handshake completes.
module alu_share_arbiter #(
  parameter int EXEC_CYCLES = 1,
  parameter int DATA_W      = 32
) (
  input logic                clk,
  input logic                reset,
  alu_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAST = 4'(EXEC_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic              prio;
  logic              gnt;
  logic [3:0]        cnt;
  logic              win;
  logic              any_req;
  logic              rsp_hs;
  logic [2:0]        sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  assign any_req = bus.req0_valid || bus.req1_valid;
  assign rsp_hs  = gnt ? bus.rsp1_ready : bus.rsp0_ready;
  assign sel_op  = win ? bus.req1_op : bus.req0_op;
  assign sel_a   = win ? bus.req1_a  : bus.req0_a;
  assign sel_b   = win ? bus.req1_b  : bus.req0_b;

  always_comb begin
    win = 1'b0;
    if (bus.req0_valid && bus.req1_valid) win = prio;
    else if (bus.req1_valid)              win = 1'b1;
  end

  always_comb begin
    state_nxt      = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.req0_ready = bus.req0_valid && !win;
        bus.req1_ready = bus.req1_valid && win;
        if (any_req) state_nxt = EXEC;
      end
      EXEC:    if (cnt == LAST) state_nxt = RESP;
      RESP:    if (rsp_hs)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      gnt            <= 1'b0;
      cnt            <= 4'd0;
      bus.alu_op     <= 3'b000;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.rsp_result <= '0;
      bus.rsp_zero   <= 1'b0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (any_req) begin
          gnt        <= win;
          cnt        <= 4'd0;
          bus.alu_op <= sel_op;
          bus.alu_a  <= sel_a;
          bus.alu_b  <= sel_b;
        end
        EXEC: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST) begin
            bus.rsp_result <= bus.alu_result;
            bus.rsp_zero   <= bus.alu_zero;
            bus.rsp0_valid <= !gnt;
            bus.rsp1_valid <= gnt;
          end
        end
        RESP: if (rsp_hs) begin
          bus.rsp0_valid <= 1'b0;
          bus.rsp1_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  assign prio = 1'b0;
`else
  // The port just served loses the next tie.
  always_ff @(posedge clk) begin
    if (!reset)                      prio <= 1'b0;
    else if (state == RESP && rsp_hs) prio <= ~gnt;
  end
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench: two arbiters (EXEC_CYCLES 1 and 4) with a bench-side ALU, checked every cycle against a transaction-level model.
module tb_alu_share_arbiter;
  localparam int EX0 = 1;
  localparam int EX1 = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.DATA_W(32)) b0 ();
  alu_share_arbiter_if #(.DATA_W(32)) b1 ();

  alu_share_arbiter #(.EXEC_CYCLES(EX0), .DATA_W(32)) u0 (.clk(clk), .reset(reset), .bus(b0));
  alu_share_arbiter #(.EXEC_CYCLES(EX1), .DATA_W(32)) u1 (.clk(clk), .reset(reset), .bus(b1));

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a << b[4:0];
      3'd3: return a | b;
      3'd4: return a & b;
      3'd5: return a >> b[4:0];
      3'd6: return ~a;
      default: return a ^ b;
    endcase
  endfunction

  function automatic int ex(input int i);
    return (i == 0) ? EX0 : EX1;
  endfunction

  // stimulus [instance][port]
  logic        rv  [2][2];
  logic [2:0]  rop [2][2];
  logic [31:0] ra  [2][2];
  logic [31:0] rb  [2][2];
  logic        rr  [2][2];
  // observed outputs
  logic        o_rdy [2][2];
  logic        o_vld [2][2];
  logic [31:0] o_res [2];
  logic        o_zero[2];
  logic [2:0]  o_op  [2];
  logic [31:0] o_a   [2];
  logic [31:0] o_b   [2];

  assign b0.req0_valid = rv[0][0]; assign b0.req0_op = rop[0][0]; assign b0.req0_a = ra[0][0]; assign b0.req0_b = rb[0][0];
  assign b0.req1_valid = rv[0][1]; assign b0.req1_op = rop[0][1]; assign b0.req1_a = ra[0][1]; assign b0.req1_b = rb[0][1];
  assign b0.rsp0_ready = rr[0][0]; assign b0.rsp1_ready = rr[0][1];
  assign b1.req0_valid = rv[1][0]; assign b1.req0_op = rop[1][0]; assign b1.req0_a = ra[1][0]; assign b1.req0_b = rb[1][0];
  assign b1.req1_valid = rv[1][1]; assign b1.req1_op = rop[1][1]; assign b1.req1_a = ra[1][1]; assign b1.req1_b = rb[1][1];
  assign b1.rsp0_ready = rr[1][0]; assign b1.rsp1_ready = rr[1][1];

  assign b0.alu_result = alu_f(b0.alu_op, b0.alu_a, b0.alu_b);
  assign b0.alu_zero   = (b0.alu_result == 32'd0);
  assign b1.alu_result = alu_f(b1.alu_op, b1.alu_a, b1.alu_b);
  assign b1.alu_zero   = (b1.alu_result == 32'd0);

  assign o_rdy[0][0] = b0.req0_ready; assign o_rdy[0][1] = b0.req1_ready;
  assign o_vld[0][0] = b0.rsp0_valid; assign o_vld[0][1] = b0.rsp1_valid;
  assign o_rdy[1][0] = b1.req0_ready; assign o_rdy[1][1] = b1.req1_ready;
  assign o_vld[1][0] = b1.rsp0_valid; assign o_vld[1][1] = b1.rsp1_valid;
  assign o_res[0] = b0.rsp_result; assign o_zero[0] = b0.rsp_zero;
  assign o_res[1] = b1.rsp_result; assign o_zero[1] = b1.rsp_zero;
  assign o_op[0] = b0.alu_op; assign o_a[0] = b0.alu_a; assign o_b[0] = b0.alu_b;
  assign o_op[1] = b1.alu_op; assign o_a[1] = b1.alu_a; assign o_b[1] = b1.alu_b;

  int tests = 0;
  int errs  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Transaction-level model: one op in flight, response due EXEC cycles after acceptance.
  logic        m_busy [2];
  int          m_age  [2];
  logic        m_gnt  [2];
  logic        m_prio [2];
  logic [2:0]  m_op   [2];
  logic [31:0] m_a    [2];
  logic [31:0] m_b    [2];
  logic [31:0] m_res  [2];
  logic        m_zero [2];

  typedef struct { int inst; int port; logic [31:0] res; logic zero; } rec_t;
  rec_t lg[$];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_age[i] = 0; m_gnt[i] = 0; m_prio[i] = 0;
      m_op[i] = 0; m_a[i] = 0; m_b[i] = 0; m_res[i] = 0; m_zero[i] = 0;
      for (int p = 0; p < 2; p++) begin
        rv[i][p] = 0; rop[i][p] = 0; ra[i][p] = 0; rb[i][p] = 0; rr[i][p] = 0;
      end
    end
  end

  logic er[2];
  logic ev[2];
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        er[0] = 0; er[1] = 0; ev[0] = 0; ev[1] = 0;
        if (!m_busy[i]) begin
          if (rv[i][0] && rv[i][1]) er[m_prio[i]] = 1;
          else if (rv[i][0])        er[0] = 1;
          else if (rv[i][1])        er[1] = 1;
        end else if (m_age[i] >= ex(i)) begin
          ev[m_gnt[i]] = 1;
        end
        chk($sformatf("u%0d.req0_ready", i), 32'(o_rdy[i][0]), 32'(er[0]));
        chk($sformatf("u%0d.req1_ready", i), 32'(o_rdy[i][1]), 32'(er[1]));
        chk($sformatf("u%0d.rsp0_valid", i), 32'(o_vld[i][0]), 32'(ev[0]));
        chk($sformatf("u%0d.rsp1_valid", i), 32'(o_vld[i][1]), 32'(ev[1]));
        chk($sformatf("u%0d.rsp_result", i), o_res[i], m_res[i]);
        chk($sformatf("u%0d.rsp_zero", i), 32'(o_zero[i]), 32'(m_zero[i]));
        chk($sformatf("u%0d.alu_op", i), 32'(o_op[i]), 32'(m_op[i]));
        chk($sformatf("u%0d.alu_a", i), o_a[i], m_a[i]);
        chk($sformatf("u%0d.alu_b", i), o_b[i], m_b[i]);

        if (!reset) begin
          m_busy[i] = 0; m_prio[i] = 0; m_op[i] = 0; m_a[i] = 0; m_b[i] = 0;
          m_res[i] = 0; m_zero[i] = 0;
        end else begin
          for (int p = 0; p < 2; p++)
            if (o_vld[i][p] && rr[i][p]) lg.push_back('{i, p, o_res[i], o_zero[i]});
          if (m_busy[i]) begin
            if (m_age[i] >= ex(i)) begin
              if (rr[i][m_gnt[i]]) begin
                m_busy[i] = 0;
`ifndef ARB_FIXED_PRIO_EN
                m_prio[i] = !m_gnt[i];
`endif
              end
            end else begin
              m_age[i]++;
              if (m_age[i] == ex(i)) begin
                m_res[i]  = alu_f(m_op[i], m_a[i], m_b[i]);
                m_zero[i] = (m_res[i] == 32'd0);
              end
            end
          end else begin
            for (int p = 0; p < 2; p++)
              if (er[p]) begin
                m_busy[i] = 1; m_age[i] = 0; m_gnt[i] = p[0];
                m_op[i] = rop[i][p]; m_a[i] = ra[i][p]; m_b[i] = rb[i][p];
              end
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for acceptance, return edges from acceptance to response valid.
  task automatic issue(input int i, input int p, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, output int lat);
    int k;
    rv[i][p] = 1; rop[i][p] = op; ra[i][p] = a; rb[i][p] = b; rr[i][p] = 1;
    k = 0;
    #1;
    while (!o_rdy[i][p] && k < 20) begin step(1); #1; k++; end
    chk($sformatf("u%0d.accept_p%0d", i, p), 32'(o_rdy[i][p]), 32'd1);
    step(1);
    rv[i][p] = 0;
    lat = 0;
    while (!o_vld[i][p] && lat < 40) begin step(1); lat++; end
    step(1);
  endtask

  int lat;
  initial begin
    reset = 0;
    step(1);
    chk_en = 1;
    step(1);
    reset = 1;
    step(1);

    // single op, port 0
    lg.delete();
    issue(0, 0, 3'b000, 32'd5, 32'd7, lat);
    chk("t1.latency", lat, EX0);
    chk("t1.count", lg.size(), 1);
    if (lg.size() == 1) begin
      chk("t1.port", lg[0].port, 0);
      chk("t1.result", lg[0].res, 32'd12);
      chk("t1.zero", 32'(lg[0].zero), 0);
    end

    // zero flag, port 1
    lg.delete();
    issue(0, 1, 3'b001, 32'h10, 32'h10, lat);
    chk("t2.count", lg.size(), 1);
    if (lg.size() == 1) begin
      chk("t2.port", lg[0].port, 1);
      chk("t2.result", lg[0].res, 32'd0);
      chk("t2.zero", 32'(lg[0].zero), 1);
    end

    // contention
    lg.delete();
    rop[0][0] = 3'b011; ra[0][0] = 32'hF0; rb[0][0] = 32'h0F;
    rop[0][1] = 3'b100; ra[0][1] = 32'hFF; rb[0][1] = 32'h3C;
    rr[0][0] = 1; rr[0][1] = 1; rv[0][0] = 1; rv[0][1] = 1;
    step(14);
    rv[0][0] = 0; rv[0][1] = 0;
    step(5);
    chk("t3.count_ge4", 32'(lg.size() >= 4), 1);
    for (int k = 0; k < 4 && k < lg.size(); k++) begin
`ifdef ARB_FIXED_PRIO_EN
      chk($sformatf("t3.port%0d", k), lg[k].port, 0);
      chk($sformatf("t3.res%0d", k), lg[k].res, 32'hFF);
`else
      chk($sformatf("t3.port%0d", k), lg[k].port, k % 2);
      chk($sformatf("t3.res%0d", k), lg[k].res, (k % 2) ? 32'h3C : 32'hFF);
`endif
    end

    // back-pressure on port 0 with port 1 waiting
    rr[0][0] = 0; rv[0][0] = 1; rop[0][0] = 3'b000; ra[0][0] = 32'd3; rb[0][0] = 32'd4;
    step(1);
    rv[0][0] = 0;
    rv[0][1] = 1; rop[0][1] = 3'b000; ra[0][1] = 32'd9; rb[0][1] = 32'd1; rr[0][1] = 1;
    step(11);
    chk("t4.hold_valid", 32'(o_vld[0][0]), 1);
    chk("t4.hold_result", o_res[0], 32'd7);
    chk("t4.blocked", 32'(o_rdy[0][1]), 0);
    rr[0][0] = 1;
    step(1);
    chk("t4.p1_ready_after_hs", 32'(o_rdy[0][1]), 1);
    step(1);
    rv[0][1] = 0;
    step(3);

    // EXEC_CYCLES = 4
    lg.delete();
    issue(1, 0, 3'b111, 32'hAAAA5555, 32'hFFFFFFFF, lat);
    chk("t5.latency", lat, EX1);
    chk("t5.count", lg.size(), 1);
    if (lg.size() == 1) chk("t5.result", lg[0].res, 32'h5555AAAA);

    // reset mid-EXEC
    lg.delete();
    rv[1][0] = 1; rop[1][0] = 3'b000; ra[1][0] = 32'd2; rb[1][0] = 32'd2; rr[1][0] = 1;
    step(1);
    rv[1][0] = 0;
    step(1);
    reset = 0;
    step(1);
    reset = 1;
    chk("t6.alu_a_cleared", o_a[1], 32'd0);
    chk("t6.result_cleared", o_res[1], 32'd0);
    step(6);
    chk("t6.no_response", lg.size(), 0);
    issue(1, 1, 3'b000, 32'd1, 32'd1, lat);
    chk("t6.count", lg.size(), 1);
    if (lg.size() == 1) chk("t6.result", lg[0].res, 32'd2);

    // random traffic, rare resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++) begin
          rv[i][p]  = ($urandom_range(0, 2) != 0);
          rop[i][p] = 3'($urandom_range(0, 7));
          ra[i][p]  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
          rb[i][p]  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
          rr[i][p]  = ($urandom_range(0, 3) != 0);
        end
      reset = ($urandom_range(0, 199) != 0);
      step(1);
    end

    reset = 1;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin rv[i][p] = 0; rr[i][p] = 1; end
    step(10);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
